// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings,
// reset/NOP constants and the buffered-instruction record.
package fetch_unit_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fifo_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {instr, pc} with first-word fall-through head
// and a flush that empties it in one cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fifo_entry_t      push_data,
  input  logic             pop,
  input  logic             flush,
  output fifo_entry_t      head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order PC tracking,
// instruction buffering and redirect/flush/misalignment handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imm_ext,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        fetch_misaligned
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] stale_q, stale_d;
  logic             misaligned_q, misaligned_d;

  logic [31:0]      pcq_mem_q [DEPTH];
  logic [PTR_W-1:0] pcq_wr_q, pcq_wr_d;
  logic [PTR_W-1:0] pcq_rd_q, pcq_rd_d;
  logic             pcq_push;

  logic [31:0]      target;
  logic [CNT_W:0]   in_flight, remaining;
  logic             credit_ok, req_fire, rsp_live, rsp_stale, dec_fire, out_valid;

  fifo_entry_t      fifo_wdata, fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign target    = redirect_pc + imm_ext;
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_C;

  assign imem_req_valid = !reset && !redirect && (state_q == ST_FETCH) && credit_ok && !fifo_full;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses drain stale credits first; live ones only exist with stale == 0.
  assign rsp_stale = imem_rsp_valid && (stale_q != '0);
  assign rsp_live  = imem_rsp_valid && (stale_q == '0) && (outstanding_q != '0);

  assign out_valid = !reset && !fifo_empty;
  assign dec_fire  = out_valid && instr_ready;

  assign in_flight = {1'b0, outstanding_q} + {1'b0, stale_q};
  assign remaining = in_flight - (CNT_W + 1)'(imem_rsp_valid && (in_flight != '0));

  assign fifo_wdata.instr = imem_rsp_data;
  assign fifo_wdata.pc    = pcq_mem_q[pcq_rd_q];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    misaligned_d  = misaligned_q;
    pcq_wr_d      = pcq_wr_q;
    pcq_rd_d      = pcq_rd_q;
    pcq_push      = 1'b0;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;

    if (redirect) begin
      // Every in-flight request, live or already stale, becomes a stale credit.
      fifo_flush    = 1'b1;
      pc_d          = target;
      outstanding_d = '0;
      stale_d       = CNT_W'(remaining);
      pcq_wr_d      = '0;
      pcq_rd_d      = '0;
      misaligned_d  = (target[1:0] != 2'b00);
      if (remaining != '0)   state_d = ST_FLUSH;
      else if (misaligned_d) state_d = ST_HALT;
      else                   state_d = ST_FETCH;
    end else begin
      if (req_fire) begin
        pc_d     = pc_q + 32'd4;
        pcq_push = 1'b1;
        pcq_wr_d = ptr_inc(pcq_wr_q);
      end
      if (rsp_live) begin
        fifo_push = 1'b1;
        pcq_rd_d  = ptr_inc(pcq_rd_q);
      end
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
      fifo_pop      = dec_fire;
      if (rsp_stale) stale_d = stale_q - CNT_W'(1);
      if ((state_q == ST_FLUSH) && (stale_d == '0))
        state_d = misaligned_q ? ST_HALT : ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
      misaligned_q  <= 1'b0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      misaligned_q  <= misaligned_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pcq_push) pcq_mem_q[pcq_wr_q] <= pc_q;
  end

  assign instr_valid      = out_valid;
  assign instr            = out_valid ? fifo_head.instr : '0;
  assign instr_pc         = out_valid ? fifo_head.pc : '0;
  assign instr_pc_plus4   = out_valid ? pc_plus4(fifo_head.pc) : '0;
  assign fetch_misaligned = misaligned_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter DEPTH, 2, combined capacity of in-flight requests plus buffered instructions.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req_valid  out  1  fetch request valid.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_addr  out  32  fetch byte address, word aligned.
REQ-008 imem_rsp_valid  in  1  response valid; in order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  in  32  fetched instruction word.
REQ-010 redirect  in  1  control-flow change from execute stage.
REQ-011 redirect_pc  in  32  PC of the branch/jump instruction.
REQ-012 imm_ext  in  32  sign-extended immediate from the extend stage.
REQ-013 instr_valid  out  1  instruction available to decode/extend.
REQ-014 instr_ready  in  1  decode accepts instruction.
REQ-015 instr  out  32  instruction word, drives the extend stage instr input.
REQ-016 instr_pc  out  32  PC of instr.
REQ-017 instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32.
REQ-018 fetch_misaligned  out  1  redirect target had target[1:0] != 0.

Function
REQ-019 States: FETCH, FLUSH, HALT. FETCH is entered from reset.
REQ-020 Issue rule: imem_req_valid=1 in FETCH when outstanding + fifo_count < DEPTH and redirect=0.
REQ-021 Request handshake: imem_req_valid && imem_req_ready. On handshake, pc <= pc + 4 and outstanding increments.
REQ-022 Address hold: imem_addr = pc. imem_addr stays stable while valid=1 and ready=0, except when a redirect occurs. The memory model tolerates that withdrawal.
REQ-023 Each non-stale response is written to a DEPTH-entry FIFO as {data, pc}. The stored pc comes from a matching in-order PC queue captured at request handshake.
REQ-024 Decode handshake: instr_valid && instr_ready pops the FIFO. instr_valid = FIFO non-empty. Outputs come from the FIFO head (first-word fall-through), so latency is request handshake -> instr_valid at 1 cycle after imem_rsp_valid.
REQ-025 A push and a pop in the same cycle are both performed, leaving fifo_count unchanged. The credit rule (REQ-020) guarantees the FIFO never overflows.
REQ-026 Redirect target computation: redirect_pc + imm_ext, modulo 2^32.
REQ-027 Redirect has priority over every same-cycle event, in order:
  - FIFO is flushed; instr_valid=0 next cycle.
  - pc <= target.
  - Any request handshake in that cycle is ignored.
  - Any response arriving in that cycle is discarded and counted as stale.
REQ-028 Redirect with aligned target and outstanding > 0 (after same-cycle decrement): go to FLUSH with stale = outstanding.
REQ-029 FLUSH behaviour:
  - No requests are issued.
  - Each response decrements stale and is discarded.
  - At stale == 0, go to FETCH.
REQ-030 Redirect with aligned target and outstanding == 0: stay in or enter FETCH. The first request at the target issues the next cycle.
REQ-031 Redirect with target[1:0] != 0: go to HALT (after FLUSH draining if outstanding > 0) and set fetch_misaligned=1.
REQ-032 HALT behaviour: no requests and no FIFO pushes. Only a new aligned redirect clears fetch_misaligned and leaves HALT.
REQ-033 A redirect in FLUSH restarts the target. stale is unchanged except for a same-cycle response decrement.
REQ-034 outstanding is never negative. A response with outstanding == 0 is ignored.

Reset
REQ-035 Reset overrides all inputs, including redirect.
REQ-036 Reset values:
  - pc=RESET_PC
  - state=FETCH
  - outstanding=0, stale=0, FIFO empty
  - imem_req_valid=0 in the reset cycle, instr_valid=0
  - fetch_misaligned=0
  - instr, instr_pc and instr_pc_plus4 = 0
REQ-037 Reset mid-transaction abandons in-flight responses. The bench model must not deliver responses to requests issued before reset.

Structure
REQ-038 Shared package: state encoding (FETCH=2'd0, FLUSH=2'd1, HALT=2'd2), RESET_PC default and the NOP constant 32'h0000_0013.
REQ-039 One sub-module, fetch_fifo: DEPTH-entry synchronous FIFO of {instr, pc} with push, pop, flush, count, empty and full.

Verification
REQ-040 Reset, then ready=1 and 1-cycle response latency, with 0x00500093/0x00100113 returned:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - instr_pc 0x0 then 0x4 with matching words.
REQ-041 instr_ready=0 for 5 cycles: at most 2 requests are issued, instr_valid is held, and instr/instr_pc stay stable.
REQ-042 Redirect with redirect_pc=0x10 and imm_ext=0xFFFFFFF8, 1 response outstanding:
  - That response is dropped.
  - Next issued imem_addr = 0x8.
  - No stale instruction reaches instr.
REQ-043 Redirect with redirect_pc=0x20 and imm_ext=0x6: fetch_misaligned=1, no further requests; a later redirect with imm_ext=0x4 resumes at 0x24.
REQ-044 Redirect, response and instr_ready all in the same cycle: redirect wins and the FIFO is empty next cycle.
REQ-045 Reset asserted mid-FLUSH: pc=RESET_PC, state FETCH, outputs at reset values the next cycle.
